// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed common-anode seven-segment driver. A per-frame snapshot of the
// selected CPU value is scanned out one digit per SCAN_DIV clocks, and halt is latched onto digit 0's dp.
module seg7_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] display,
  input  logic [31:0] cycle_count,
  input  logic        halt,
  input  logic        sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [31:0]      shadow_reg;
  logic             halt_seen_reg;
  logic             tick;
  logic [7:0][3:0]  nib_arr;
  logic [7:0]       lead_zero;

  assign tick = (cnt_reg == CNT_MAX);

  // lead_zero[i] is set when every nibble from digit i upward is zero
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign nib_arr[gi] = shadow_reg[4*gi +: 4];
      if (gi == 0) begin : g_first
        assign lead_zero[gi] = 1'b0;
      end else begin : g_upper
        assign lead_zero[gi] = (shadow_reg[31:4*gi] == '0);
      end
    end
  endgenerate

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shadow_reg    <= '0;
      halt_seen_reg <= 1'b0;
      an            <= 8'hFF;
      seg           <= 7'h7F;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      if (tick) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 3'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // Snapshot only at the frame boundary so a frame never mixes two values
      frame_done <= tick && (idx_reg == 3'd7);
      if (tick && (idx_reg == 3'd7))
        shadow_reg <= sel ? cycle_count : display;

      if (halt)
        halt_seen_reg <= 1'b1;

      an  <= ~(8'b1 << idx_reg);
      seg <= (LZ_BLANK && lead_zero[idx_reg]) ? 7'h7F : hex7(nib_arr[idx_reg]);
      dp  <= ~((idx_reg == 3'd0) && halt_seen_reg);
    end
  end

endmodule
